// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned ILEN_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // RV32 base encoding view of the instruction register
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts cycles while run is high and flags the last allowed
// cycle so the fetch FSM can abort on the following edge.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count cycles spent waiting; restart from zero whenever the wait ends
    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and performs one instruction-memory read per fetch_en
// over a req/ack handshake, landing the word in the instruction register.
// Define FETCH_TIMEOUT_EN to abort a fetch with a NOP after TIMEOUT_CYC cycles.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_en,
    input  logic            pc_inc,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic            busy,
    output logic            fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            mem_req_q, mem_req_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            timeout_c;

`ifdef FETCH_TIMEOUT_EN
    logic wd_run_c;

    assign wd_run_c = (state_q == WAIT);

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (wd_run_c),
        .expired_c (timeout_c)
    );
`else
    // Without the watchdog a WAIT only ends on mem_ack
    logic unused_timeout_cfg_c;
    assign unused_timeout_cfg_c = ^TIMEOUT_CYC;
    assign timeout_c            = 1'b0;
`endif

    // Next-state, PC update and fetch handshake
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        mem_req_d     = mem_req_q;
        fault_d       = fault_q;

        unique case (state_q)
            IDLE: begin
                // PC only moves while no fetch is outstanding; load beats increment
                if (pc_load) begin
                    pc_d = pc_target;
                end else if (pc_inc) begin
                    pc_d = pc_q + XLEN'(ILEN_BYTES);
                end
                if (pc_d != pc_q) begin
                    instr_valid_d = 1'b0;
                end
                // A fetch in the same cycle as a PC update uses the old PC
                if (fetch_en) begin
                    if (pc_q[1:0] == 2'b00) begin
                        mem_req_d     = 1'b1;
                        mem_addr_d    = pc_q;
                        instr_valid_d = 1'b0;
                        state_d       = WAIT;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ack wins over a coincident watchdog expiry
                if (mem_ack) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = IDLE;
                end else if (timeout_c) begin
                    instr_d       = XLEN'(NOP_INSTR);
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d == WAIT);
    end

    // State and datapath registers; reset drops mem_req immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            mem_req_q     <= mem_req_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule
